// File: rtl/trace_pkg.sv
// Shared types, ASCII constants and helpers for the trace character emitter.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_EMIT,
        ST_GAP
    } state_t;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;

    localparam logic [5:0]  REC_LEN_REG = 6'd29;
    localparam logic [5:0]  REC_LEN_MEM = 6'd35;
    localparam logic [13:0] TIME_MAX    = 14'd9999;

    // 0-9 map to '0'-'9'; 10-15 map to 'a'-'f' or 'A'-'F'.
    function automatic logic [7:0] hex2ascii(input logic [3:0] nibble, input logic lower);
        if (nibble < 4'd10)
            return 8'h30 + {4'h0, nibble};
        else if (lower)
            return 8'h57 + {4'h0, nibble};
        else
            return 8'h37 + {4'h0, nibble};
    endfunction

    // Nibble k of a 32-bit word, k=7 is the most significant.
    function automatic logic [3:0] nib32(input logic [31:0] w, input logic [2:0] k);
        return 4'(w >> {k, 2'b00});
    endfunction

endpackage

// File: rtl/trace_char_emitter_bin2bcd14.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3, one bit per cycle).
module bin2bcd14
    import trace_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        done,
    output logic [15:0] bcd
);

    logic [13:0] sh;
    logic [15:0] acc;
    logic [15:0] acc_adj;
    logic [3:0]  cnt;
    logic        running;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Correct every BCD digit before the next left shift.
    always_comb begin
        acc_adj = {add3(acc[15:12]), add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
    end

    // Load on start, then shift one binary bit into the BCD accumulator per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh      <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            sh      <= bin;
            acc     <= '0;
            cnt     <= 4'd14;
            running <= 1'b1;
        end else if (running) begin
            {acc, sh} <= {acc_adj, sh} << 1;
            cnt       <= cnt - 4'd1;
            if (cnt == 4'd1)
                running <= 1'b0;
        end
    end

    // Done is high during the cycle whose closing edge performs the final shift,
    // so the result is valid from the following cycle on and held until the next start.
    assign done = running && (cnt == 4'd1);
    assign bcd  = acc;

endmodule

// File: rtl/trace_char_emitter.sv
// Serialises one CPU write-back record into an ASCII trace line, one character per clock.
module trace_char_emitter
    import trace_pkg::*;
#(
    parameter logic [7:0]  IDLE_CHAR = 8'h20,
    parameter int unsigned GAP       = 2,
    parameter bit          LOWER_HEX = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_mem,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_reg,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic        char_valid,
    output logic        busy,
    output logic        time_sat
);

    state_t      state, state_next;
    logic        accept;
    logic        is_mem_q;
    logic [31:0] pc_q, addr_q, data_q;
    logic [4:0]  reg_q;
    logic [5:0]  idx, last_idx, tail;
    logic [3:0]  gap_cnt;
    logic [7:0]  lut_char;
    logic [3:0]  reg_tens;
    logic [4:0]  reg_units;
    logic        bcd_done;
    logic [15:0] bcd;

    function automatic logic [13:0] sat_time(input logic [13:0] t);
        return (t > TIME_MAX) ? TIME_MAX : t;
    endfunction

    function automatic logic [3:0] dec_tens(input logic [4:0] r);
        if (r >= 5'd30)      return 4'd3;
        else if (r >= 5'd20) return 4'd2;
        else if (r >= 5'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    assign in_ready  = (state == ST_IDLE) && reset;
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_idx  = is_mem_q ? (REC_LEN_MEM - 6'd1) : (REC_LEN_REG - 6'd1);
    assign reg_tens  = dec_tens(reg_q);
    assign reg_units = reg_q - ({1'b0, reg_tens} * 5'd10);

    bin2bcd14 u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (sat_time(in_time)),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: IDLE -> CONV -> EMIT -> (GAP) -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)   state_next = ST_CONV;
            ST_CONV: if (bcd_done) state_next = ST_EMIT;
            ST_EMIT: if (idx == last_idx)
                         state_next = (GAP == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (gap_cnt == 4'(GAP - 1)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Character selected by the record index; the tail after the variable field
    // starts at 18 for register records and 24 for memory records.
    always_comb begin
        lut_char = IDLE_CHAR;
        tail     = idx - (is_mem_q ? 6'd24 : 6'd18);
        if (idx == 6'd0)
            lut_char = CH_CARET;
        else if (idx <= 6'd4)
            lut_char = hex2ascii(nib32({16'h0, bcd}, 3'(6'd4 - idx)), LOWER_HEX);
        else if (idx == 6'd5)
            lut_char = CH_AT;
        else if (idx <= 6'd13)
            lut_char = hex2ascii(nib32(pc_q, 3'(6'd13 - idx)), LOWER_HEX);
        else if (idx == 6'd14)
            lut_char = CH_COLON;
        else if (idx == 6'd15)
            lut_char = is_mem_q ? CH_STAR : CH_DOLLAR;
        else if (is_mem_q && idx <= 6'd23)
            lut_char = hex2ascii(nib32(addr_q, 3'(6'd23 - idx)), LOWER_HEX);
        else if (!is_mem_q && idx == 6'd16)
            lut_char = hex2ascii(reg_tens, LOWER_HEX);
        else if (!is_mem_q && idx == 6'd17)
            lut_char = hex2ascii(reg_units[3:0], LOWER_HEX);
        else if (tail == 6'd0)
            lut_char = CH_LT;
        else if (tail == 6'd1)
            lut_char = CH_EQ;
        else if (tail <= 6'd9)
            lut_char = hex2ascii(nib32(data_q, 3'(6'd9 - tail)), LOWER_HEX);
        else
            lut_char = CH_HASH;
    end

    // Holding registers, index/gap counters and the registered character output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_mem_q   <= 1'b0;
            pc_q       <= '0;
            reg_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
            char       <= IDLE_CHAR;
            char_valid <= 1'b0;
            time_sat   <= 1'b0;
        end else begin
            time_sat <= accept && (in_time > TIME_MAX);
            if (accept) begin
                is_mem_q <= in_is_mem;
                pc_q     <= in_pc;
                reg_q    <= in_reg;
                addr_q   <= in_addr;
                data_q   <= in_data;
            end
            if (state == ST_EMIT) begin
                char       <= lut_char;
                char_valid <= 1'b1;
                idx        <= (idx == last_idx) ? 6'd0 : idx + 6'd1;
            end else begin
                char       <= IDLE_CHAR;
                char_valid <= 1'b0;
                idx        <= '0;
            end
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 4'd1 : 4'd0;
        end
    end

endmodule
